sample_rle_compressor: RTL and testbench



---
 rtl/sample_rle_compressor.sv | 170 +++++++++++++++++
 tb/tb_sample_rle_compressor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_rle_compressor.sv
// Run-length compressor: literal/run-count stream into an internal FIFO with valid/ready backpressure.
// Optional stat_in/stat_out counters are enabled by defining SAMPLE_RLE_STATS_EN.
module sample_rle_compressor #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [W-1:0]           in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   idle
`ifdef SAMPLE_RLE_STATS_EN
  ,
  output logic [31:0]            stat_in,
  output logic [31:0]            stat_out
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [W-1:0] MAXC = {{(W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {INIT, SINGLE, RUN} state_t;

  state_t         state_q, state_d, state_a;
  logic [W-1:0]   cntr_q, cntr_d, cntr_a;
  logic [W-1:0]   last_q, last_d;
  logic           pend_q, pend_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]    level_q, level_d, free, need;
  logic           accept, pop, fl_req, fl_cost, same;
  logic [1:0]     np_a, np;
  logic [W-1:0]   pd0, pd1;

  assign free       = (AW+1)'(DEPTH) - level_q;
  assign in_ready   = (free >= (AW+1)'(2)) && !pend_q;
  assign accept     = in_valid && in_ready;
  assign pop        = out_ready && (level_q != '0);
  assign out_valid  = (level_q != '0);
  assign out_data   = mem_q[rd_q];
  assign fifo_level = level_q;
  assign idle       = (state_q != RUN) && (level_q == '0) && !pend_q;
  assign same       = (in_data == last_q);

  always_comb begin
    state_a = state_q;
    cntr_a  = cntr_q;
    last_d  = last_q;
    np_a    = 2'd0;
    pd0     = in_data;
    pd1     = in_data;
    if (accept) begin
      last_d = in_data;
      case (state_q)
        INIT: begin
          np_a    = 2'd1;
          state_a = SINGLE;
        end
        SINGLE: begin
          np_a = 2'd1;
          if (same) begin
            cntr_a  = '0;
            state_a = RUN;
          end
        end
        RUN: begin
          if (same) begin
            if (cntr_q == MAXC) begin
              np_a   = 2'd1;
              pd0    = '1;
              cntr_a = '0;
            end else begin
              cntr_a = cntr_q + 1'b1;
            end
          end else begin
            np_a    = 2'd2;
            pd0     = cntr_q;
            state_a = SINGLE;
          end
        end
        default: state_a = INIT;
      endcase
    end

    state_d = state_a;
    cntr_d  = cntr_a;
    np      = np_a;
    pend_d  = 1'b0;
    fl_req  = flush || pend_q;
    // A flush issued against an open run reserves a push slot even when the
    // coincident accept closed that run; it is then deferred one cycle.
    fl_cost = (state_a == RUN) || (accept && (state_q == RUN));
    need    = (AW+1)'(np_a) + (AW+1)'(fl_cost);
    if (fl_req) begin
      if (need > (AW+1)'(2) || need > free) begin
        pend_d = 1'b1;
      end else begin
        state_d = INIT;
        cntr_d  = '0;
        if (state_a == RUN) begin
          np = np_a + 2'd1;
          if (np_a == 2'd0) pd0 = cntr_a;
          else              pd1 = cntr_a;
        end
      end
    end

    wr_d    = wr_q + AW'(np);
    rd_d    = rd_q + AW'(pop);
    level_d = level_q + (AW+1)'(np) - (AW+1)'(pop);

    if (clear) begin
      state_d = INIT;
      cntr_d  = '0;
      pend_d  = 1'b0;
      np      = 2'd0;
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cntr_q  <= '0;
      last_q  <= '0;
      pend_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (np != 2'd0) mem_q[wr_q] <= pd0;
    if (np == 2'd2) mem_q[wr_q + AW'(1)] <= pd1;
  end

`ifdef SAMPLE_RLE_STATS_EN
  logic [31:0] stat_in_q, stat_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
    end else begin
      if (accept && !clear && stat_in_q != '1) stat_in_q <= stat_in_q + 32'd1;
      if (pop && stat_out_q != '1)             stat_out_q <= stat_out_q + 32'd1;
    end
  end

  assign stat_in  = stat_in_q;
  assign stat_out = stat_out_q;
`endif
endmodule

// File: tb/tb_sample_rle_compressor.sv
// Scoreboard bench for sample_rle_compressor (W=16, DEPTH=8): directed vectors, queued expectations.
module tb_sample_rle_compressor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  fifo_level;
  logic        idle;
`ifdef SAMPLE_RLE_STATS_EN
  logic [31:0] stat_in, stat_out;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  sample_rle_compressor #(.W(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .idle(idle)
`ifdef SAMPLE_RLE_STATS_EN
    , .stat_in(stat_in), .stat_out(stat_out)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every word the sink takes is checked against the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      chk("level_bound", 32'(fifo_level > 4'd8), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected none", out_data);
        end else begin
          chk("out_word", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic fl);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    flush    = fl;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while ((fifo_level != 4'd0 || exp_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_level"}, 32'(fifo_level), 32'd0);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Distinct literals
    exp_q.push_back(16'h1234); exp_q.push_back(16'h5678); exp_q.push_back(16'h9ABC);
    send(16'h1234, 1'b0);
    send(16'h5678, 1'b0);
    send(16'h9ABC, 1'b0);
    drain("lit");
    chk("lit_idle", 32'(idle), 32'd1);

    // Short run: count and closing literal pushed in one cycle
    out_ready = 1'b0;
    exp_q.push_back(16'hAAAA); exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'h0003); exp_q.push_back(16'h5555);
    for (int i = 0; i < 5; i++) send(16'hAAAA, 1'b0);
    chk("run_level_before", 32'(fifo_level), 32'd2);
    send(16'h5555, 1'b0);
    chk("run_level_after", 32'(fifo_level), 32'd4);
    drain("run");

    // 65537 zeros: one continuation word then terminal count 0 on flush
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000);
    for (int i = 0; i < 65537; i++) send(16'h0000, 1'b0);
    pulse_flush();
    drain("long");
    // From INIT two zeros give two literals; a stale SINGLE would give 0,count 1
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    pulse_flush();
    drain("post_flush");

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) exp_q.push_back(16'h0100 + 16'(i));
    for (int i = 0; i < 6; i++) send(16'h0100 + 16'(i), 1'b0);
    chk("bp_ready_at6", 32'(in_ready), 32'd1);
    send(16'h0106, 1'b0);
    chk("bp_level7", 32'(fifo_level), 32'd7);
    chk("bp_ready_at7", 32'(in_ready), 32'd0);
    in_data = 16'h0107;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_held_level", 32'(fifo_level), 32'd7);
    out_ready = 1'b1;
    send(16'h0107, 1'b0);
    send(16'h0108, 1'b0);
    send(16'h0109, 1'b0);
    drain("bp");

    // Flush coincident with run-ending accept at level 5
    out_ready = 1'b0;
    exp_q.push_back(16'h3000); exp_q.push_back(16'h3001); exp_q.push_back(16'h3002);
    exp_q.push_back(16'h4444); exp_q.push_back(16'h4444);
    exp_q.push_back(16'h0001); exp_q.push_back(16'h7777);
    send(16'h3000, 1'b0);
    send(16'h3001, 1'b0);
    send(16'h3002, 1'b0);
    send(16'h4444, 1'b0);
    send(16'h4444, 1'b0);
    send(16'h4444, 1'b0);
    chk("cf_level5", 32'(fifo_level), 32'd5);
    send(16'h7777, 1'b1);
    chk("cf_level7", 32'(fifo_level), 32'd7);
    chk("cf_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("cf_no_extra_push", 32'(fifo_level), 32'd7);
    drain("cf");
    exp_q.push_back(16'h7777); exp_q.push_back(16'h7777); exp_q.push_back(16'h0000);
    send(16'h7777, 1'b0);
    send(16'h7777, 1'b0);
    pulse_flush();
    drain("cf_literal");

    // Clear mid-run with 3 words queued
    out_ready = 1'b0;
    send(16'h0001, 1'b0);
    send(16'h5A5A, 1'b0);
    send(16'h5A5A, 1'b0);
    send(16'h5A5A, 1'b0);
    chk("clr_level3", 32'(fifo_level), 32'd3);
    clear = 1'b1;
    in_data = 16'h5A5A;
    in_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_level", 32'(fifo_level), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(16'h5A5A); exp_q.push_back(16'h5A5A); exp_q.push_back(16'h0000);
    out_ready = 1'b1;
    send(16'h5A5A, 1'b0);
    send(16'h5A5A, 1'b0);
    pulse_flush();
    drain("clr");
    chk("final_idle", 32'(idle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
